// File: rtl/de_pipe_reg.sv
// D/E pipeline register with load-use stall detection, bubble injection,
// M-stage Tnew hand-off and a saturating stall-cycle counter.
module de_pipe_reg #(
  parameter int TW   = 2,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Clear,
  input  logic [31:0]     D_PC,
  input  logic [31:0]     D_Instr,
  input  logic [31:0]     D_RD1,
  input  logic [31:0]     D_RD2,
  input  logic [31:0]     D_Ext,
  input  logic [4:0]      D_Rs,
  input  logic [4:0]      D_Rt,
  input  logic [4:0]      D_Addr,
  input  logic            D_GRFWE,
  input  logic [TW-1:0]   D_Tnew,
  input  logic            D_UseRs,
  input  logic            D_UseRt,
  input  logic [TW-1:0]   D_TuseRs,
  input  logic [TW-1:0]   D_TuseRt,
  input  logic            M_GRFWE,
  input  logic [4:0]      M_Addr,
  input  logic [TW-1:0]   M_Tnew,
  output logic            Stall,
  output logic [31:0]     E_PC,
  output logic [31:0]     E_Instr,
  output logic [31:0]     E_RD1,
  output logic [31:0]     E_RD2,
  output logic [31:0]     E_Ext,
  output logic [4:0]      E_Rs,
  output logic [4:0]      E_Rt,
  output logic [4:0]      E_Addr,
  output logic            E_GRFWE,
  output logic [TW-1:0]   E_Tnew,
  output logic [TW-1:0]   EM_Tnew,
  output logic [CNTW-1:0] StallCnt
);

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic [31:0]   rd1;
    logic [31:0]   rd2;
    logic [31:0]   ext;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    addr;
    logic          grfwe;
    logic [TW-1:0] tnew;
  } e_stage_t;

  e_stage_t d_fields;
  e_stage_t e_q;

  logic stall_rs_e, stall_rs_m, stall_rt_e, stall_rt_m;

  assign d_fields = '{pc: D_PC, instr: D_Instr, rd1: D_RD1, rd2: D_RD2,
                      ext: D_Ext, rs: D_Rs, rt: D_Rt, addr: D_Addr,
                      grfwe: D_GRFWE, tnew: D_Tnew};

  // A producer only blocks D when its result arrives strictly later than D
  // needs it; equal timing is covered by the forwarding mux. $zero never hazards.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    stall_rs_e = D_UseRs && (D_Rs != 5'd0) && e_q.grfwe &&
                 (e_q.addr == D_Rs) && (e_q.tnew > D_TuseRs);
    stall_rs_m = D_UseRs && (D_Rs != 5'd0) && M_GRFWE &&
                 (M_Addr == D_Rs) && (M_Tnew > D_TuseRs);
    stall_rt_e = D_UseRt && (D_Rt != 5'd0) && e_q.grfwe &&
                 (e_q.addr == D_Rt) && (e_q.tnew > D_TuseRt);
    stall_rt_m = D_UseRt && (D_Rt != 5'd0) && M_GRFWE &&
                 (M_Addr == D_Rt) && (M_Tnew > D_TuseRt);
    Stall      = !reset && (stall_rs_e || stall_rs_m || stall_rt_e || stall_rt_m);
  end

  // A bubble is the all-zero E record: no write enable, no destination, Tnew 0.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q      <= '0;
      StallCnt <= '0;
    end else begin
      if (Clear || Stall) e_q <= '0;
      else                e_q <= d_fields;
      if (Stall && (StallCnt != '1)) StallCnt <= StallCnt + CNTW'(1);
    end
  end

  assign E_PC    = e_q.pc;
  assign E_Instr = e_q.instr;
  assign E_RD1   = e_q.rd1;
  assign E_RD2   = e_q.rd2;
  assign E_Ext   = e_q.ext;
  assign E_Rs    = e_q.rs;
  assign E_Rt    = e_q.rt;
  assign E_Addr  = e_q.addr;
  assign E_GRFWE = e_q.grfwe;
  assign E_Tnew  = e_q.tnew;
  assign EM_Tnew = (e_q.tnew == '0) ? '0 : e_q.tnew - TW'(1);

endmodule

// File: tb/tb_de_pipe_reg.sv
// Directed-vector bench for de_pipe_reg: a default instance plus a CNTW=4
// instance sharing stimulus, used to exercise counter saturation.
module tb_de_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [31:0] d_pc, d_instr, d_rd1, d_rd2, d_ext;
  logic [4:0]  d_rs, d_rt, d_addr, m_addr;
  logic        d_grfwe, d_use_rs, d_use_rt, m_grfwe;
  logic [1:0]  d_tnew, d_tuse_rs, d_tuse_rt, m_tnew;

  logic        stall;
  logic [31:0] e_pc, e_instr, e_rd1, e_rd2, e_ext;
  logic [4:0]  e_rs, e_rt, e_addr;
  logic        e_grfwe;
  logic [1:0]  e_tnew, em_tnew;
  logic [31:0] stall_cnt;

  logic        stall4;
  logic [31:0] e4_pc, e4_instr, e4_rd1, e4_rd2, e4_ext;
  logic [4:0]  e4_rs, e4_rt, e4_addr;
  logic        e4_grfwe;
  logic [1:0]  e4_tnew, em4_tnew;
  logic [3:0]  stall_cnt4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  de_pipe_reg #(.TW(2), .CNTW(32)) dut (
    .clk(clk), .reset(reset), .Clear(clear),
    .D_PC(d_pc), .D_Instr(d_instr), .D_RD1(d_rd1), .D_RD2(d_rd2), .D_Ext(d_ext),
    .D_Rs(d_rs), .D_Rt(d_rt), .D_Addr(d_addr), .D_GRFWE(d_grfwe), .D_Tnew(d_tnew),
    .D_UseRs(d_use_rs), .D_UseRt(d_use_rt), .D_TuseRs(d_tuse_rs), .D_TuseRt(d_tuse_rt),
    .M_GRFWE(m_grfwe), .M_Addr(m_addr), .M_Tnew(m_tnew),
    .Stall(stall), .E_PC(e_pc), .E_Instr(e_instr), .E_RD1(e_rd1), .E_RD2(e_rd2),
    .E_Ext(e_ext), .E_Rs(e_rs), .E_Rt(e_rt), .E_Addr(e_addr), .E_GRFWE(e_grfwe),
    .E_Tnew(e_tnew), .EM_Tnew(em_tnew), .StallCnt(stall_cnt)
  );

  de_pipe_reg #(.TW(2), .CNTW(4)) dut4 (
    .clk(clk), .reset(reset), .Clear(clear),
    .D_PC(d_pc), .D_Instr(d_instr), .D_RD1(d_rd1), .D_RD2(d_rd2), .D_Ext(d_ext),
    .D_Rs(d_rs), .D_Rt(d_rt), .D_Addr(d_addr), .D_GRFWE(d_grfwe), .D_Tnew(d_tnew),
    .D_UseRs(d_use_rs), .D_UseRt(d_use_rt), .D_TuseRs(d_tuse_rs), .D_TuseRt(d_tuse_rt),
    .M_GRFWE(m_grfwe), .M_Addr(m_addr), .M_Tnew(m_tnew),
    .Stall(stall4), .E_PC(e4_pc), .E_Instr(e4_instr), .E_RD1(e4_rd1), .E_RD2(e4_rd2),
    .E_Ext(e4_ext), .E_Rs(e4_rs), .E_Rt(e4_rt), .E_Addr(e4_addr), .E_GRFWE(e4_grfwe),
    .E_Tnew(e4_tnew), .EM_Tnew(em4_tnew), .StallCnt(stall_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0;
    d_pc = '0; d_instr = '0; d_rd1 = '0; d_rd2 = '0; d_ext = '0;
    d_rs = '0; d_rt = '0; d_addr = '0; d_grfwe = 1'b0; d_tnew = '0;
    d_use_rs = 1'b0; d_use_rt = 1'b0; d_tuse_rs = '0; d_tuse_rt = '0;
    m_grfwe = 1'b0; m_addr = '0; m_tnew = '0;
  endtask

  initial begin
    idle_inputs();
    // Reset with a live D instruction and an M hazard present
    reset = 1'b1;
    d_grfwe = 1'b1; d_addr = 5'd5; d_pc = 32'h2000; d_tnew = 2'd2;
    d_use_rs = 1'b1; d_rs = 5'd5;
    m_grfwe = 1'b1; m_addr = 5'd5; m_tnew = 2'd3;
    #1;
    check("stall_in_reset", {31'd0, stall}, 32'd0);
    step();
    check("rst_e_pc", e_pc, 32'd0);
    check("rst_e_grfwe", {31'd0, e_grfwe}, 32'd0);
    check("rst_e_addr", {27'd0, e_addr}, 32'd0);
    check("rst_e_tnew", {30'd0, e_tnew}, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    step();

    // Normal load
    reset = 1'b0;
    idle_inputs();
    d_pc = 32'h3000; d_instr = 32'h8c08_0000; d_rd1 = 32'h1234; d_rd2 = 32'h5678;
    d_ext = 32'h0000_0010; d_rs = 5'd1; d_rt = 5'd8; d_addr = 5'd8;
    d_grfwe = 1'b1; d_tnew = 2'd2;
    #1;
    check("load_no_stall", {31'd0, stall}, 32'd0);
    step();
    check("load_e_pc", e_pc, 32'h3000);
    check("load_e_rd1", e_rd1, 32'h1234);
    check("load_e_rd2", e_rd2, 32'h5678);
    check("load_e_addr", {27'd0, e_addr}, 32'd8);
    check("load_e_tnew", {30'd0, e_tnew}, 32'd2);
    check("load_em_tnew", {30'd0, em_tnew}, 32'd1);
    check("load_e_grfwe", {31'd0, e_grfwe}, 32'd1);

    // Load-use: D reads $8 right away while the lw sits in E
    idle_inputs();
    d_pc = 32'h3004; d_rs = 5'd8; d_use_rs = 1'b1; d_tuse_rs = 2'd0;
    d_addr = 5'd9; d_grfwe = 1'b1; d_tnew = 2'd1;
    #1;
    check("lu_stall_e", {31'd0, stall}, 32'd1);
    step();
    check("lu_bubble_pc", e_pc, 32'd0);
    check("lu_bubble_grfwe", {31'd0, e_grfwe}, 32'd0);
    check("lu_bubble_tnew", {30'd0, e_tnew}, 32'd0);
    check("lu_em_tnew_sat", {30'd0, em_tnew}, 32'd0);
    check("lu_cnt1", stall_cnt, 32'd1);
    m_grfwe = 1'b1; m_addr = 5'd8; m_tnew = 2'd1;
    #1;
    check("lu_stall_m", {31'd0, stall}, 32'd1);
    step();
    check("lu_cnt2", stall_cnt, 32'd2);
    m_tnew = 2'd0;
    #1;
    check("lu_release", {31'd0, stall}, 32'd0);
    step();
    check("lu_e_pc", e_pc, 32'h3004);
    check("lu_e_addr", {27'd0, e_addr}, 32'd9);
    check("lu_em_tnew", {30'd0, em_tnew}, 32'd0);
    check("lu_cnt_hold", stall_cnt, 32'd2);

    // Strict comparison boundary: E holds $9 with Tnew=1
    idle_inputs();
    d_use_rs = 1'b1; d_rs = 5'd9; d_tuse_rs = 2'd1;
    #1;
    check("eq_no_stall", {31'd0, stall}, 32'd0);
    d_tuse_rs = 2'd0;
    #1;
    check("gt_stall_rs", {31'd0, stall}, 32'd1);
    d_use_rs = 1'b0; d_use_rt = 1'b1; d_rt = 5'd9; d_tuse_rt = 2'd0;
    #1;
    check("gt_stall_rt", {31'd0, stall}, 32'd1);
    d_use_rt = 1'b0;
    #1;
    check("unused_no_stall", {31'd0, stall}, 32'd0);
    // Instruction targeting $zero
    d_pc = 32'h3008; d_addr = 5'd0; d_grfwe = 1'b1; d_tnew = 2'd2;
    step();
    check("zero_e_tnew", {30'd0, e_tnew}, 32'd2);
    idle_inputs();
    d_use_rs = 1'b1; d_rs = 5'd0; d_tuse_rs = 2'd0;
    #1;
    check("zero_no_stall", {31'd0, stall}, 32'd0);

    // Clear flushes a valid, hazard-free D
    idle_inputs();
    d_pc = 32'h300c; d_addr = 5'd10; d_grfwe = 1'b1; d_tnew = 2'd1; clear = 1'b1;
    #1;
    check("clr_no_stall", {31'd0, stall}, 32'd0);
    step();
    check("clr_e_pc", e_pc, 32'd0);
    check("clr_e_grfwe", {31'd0, e_grfwe}, 32'd0);
    check("clr_cnt", stall_cnt, 32'd2);
    idle_inputs();
    d_pc = 32'h3010; d_addr = 5'd11; d_grfwe = 1'b1; d_tnew = 2'd3;
    step();
    check("t3_e_pc", e_pc, 32'h3010);
    check("t3_em_tnew", {30'd0, em_tnew}, 32'd2);

    // Clear together with a hazard
    idle_inputs();
    d_pc = 32'h3014; d_use_rt = 1'b1; d_rt = 5'd11; d_tuse_rt = 2'd1;
    d_addr = 5'd12; d_grfwe = 1'b1; clear = 1'b1;
    #1;
    check("clr_hz_stall", {31'd0, stall}, 32'd1);
    step();
    check("clr_hz_e_pc", e_pc, 32'd0);
    check("clr_hz_cnt", stall_cnt, 32'd3);
    clear = 1'b0;

    // M-stage rt hazard gated by M write enable
    m_addr = 5'd11; m_tnew = 2'd2;
    #1;
    check("m_we_gate", {31'd0, stall}, 32'd0);
    m_grfwe = 1'b1;
    #1;
    check("m_rt_stall", {31'd0, stall}, 32'd1);

    // Saturation of the 4-bit counter (currently at 3)
    for (int i = 0; i < 12; i++) step();
    check("sat4_at_15", {28'd0, stall_cnt4}, 32'd15);
    check("cnt32_at_15", stall_cnt, 32'd15);
    for (int i = 0; i < 3; i++) step();
    check("sat4_hold", {28'd0, stall_cnt4}, 32'd15);
    check("cnt32_at_18", stall_cnt, 32'd18);
    check("sat4_stall", {31'd0, stall4}, 32'd1);

    // Reset mid-stall
    reset = 1'b1;
    #1;
    check("rst_mid_stall", {31'd0, stall}, 32'd0);
    step();
    check("rst_mid_cnt", stall_cnt, 32'd0);
    check("rst_mid_cnt4", {28'd0, stall_cnt4}, 32'd0);
    check("rst_mid_e_pc", e_pc, 32'd0);
    check("rst_mid_e4_any", {31'd0, |{e4_pc, e4_instr, e4_rd1, e4_rd2, e4_ext,
                                      e4_rs, e4_rt, e4_addr, e4_grfwe, e4_tnew, em4_tnew}}, 32'd0);
    check("rst_mid_e_any", {31'd0, |{e_instr, e_rd1, e_rd2, e_ext, e_rs, e_rt}}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_stall", {31'd0, stall}, 32'd1);
    step();
    check("post_rst_cnt", stall_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
